// File: rtl/sequence_game_pkg.sv
// Shared state encodings and LFSR constants for the growing-sequence memory game.
package sequence_game_pkg;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_EXTEND       = 4'd1,
        S_PLAY_ON      = 4'd2,
        S_PLAY_GAP     = 4'd3,
        S_WAIT_KEY     = 4'd4,
        S_CHECK        = 4'd5,
        S_WAIT_RELEASE = 4'd6,
        S_WON          = 4'd7,
        S_LOST         = 4'd8
    } state_e;

    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sequence_game_core_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sequence_game_core.sv
// Growing-sequence ("Simon") game: extend, play back with timed note/gap phases,
// then check the player's presses one by one under a response timeout.
module sequence_game_core
    import sequence_game_pkg::*;
#(
    parameter int          NUM_KEYS       = 4,
    parameter int          MAX_LEN        = 16,
    parameter int          NOTE_CYCLES    = 25000000,
    parameter int          GAP_CYCLES     = 12500000,
    parameter int          TIMEOUT_CYCLES = 250000000,
    parameter logic [15:0] SEED           = 16'hACE1,
    localparam int         NW             = $clog2(NUM_KEYS),
    localparam int         LW             = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] note_out,
    output logic [3:0]          state_out,
    output logic [LW-1:0]       level,
    output logic                won,
    output logic                lost
);

    localparam int AW    = $clog2(MAX_LEN);
    localparam int MAX_A = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int MAXC  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int TW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_e              state_q, state_d;
    logic [LW-1:0]       level_q, level_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [NUM_KEYS-1:0] prev_keys_q, prev_keys_d;
    logic [NUM_KEYS-1:0] cap_q, cap_d;
    logic [NW-1:0]       mem_q [MAX_LEN];
    logic [NW-1:0]       mem_d [MAX_LEN];

    logic [NUM_KEYS-1:0] exp_oh;
    logic [NW-1:0]       new_note, cur_note;
    logic                press, last, t_load, t_done;
    logic [TW-1:0]       t_val;

    // One timer serves note, gap and response phases; each phase loads it on entry
    phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    assign new_note    = NW'(lfsr_q[NW-1:0] % NUM_KEYS);
    assign cur_note    = mem_q[idx_q[AW-1:0]];
    assign press       = (prev_keys_q == '0) && (key_in != '0);
    assign last        = (idx_q == level_q - 1'b1);
    assign lfsr_d      = lfsr_next(lfsr_q);
    assign prev_keys_d = key_in;

    always_comb begin
        exp_oh           = '0;
        exp_oh[cur_note] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        mem_d   = mem_q;
        t_load  = 1'b0;
        t_val   = '0;
        case (state_q)
            S_IDLE, S_WON, S_LOST: begin
                if (start) begin
                    state_d = S_EXTEND;
                    level_d = '0;
                end
            end
            S_EXTEND: begin
                mem_d[level_q[AW-1:0]] = new_note;
                level_d = level_q + 1'b1;
                idx_d   = '0;
                state_d = S_PLAY_ON;
                t_load  = 1'b1;
                t_val   = TW'(NOTE_CYCLES - 1);
            end
            S_PLAY_ON: begin
                if (t_done) begin
                    state_d = S_PLAY_GAP;
                    t_load  = 1'b1;
                    t_val   = TW'(GAP_CYCLES - 1);
                end
            end
            S_PLAY_GAP: begin
                if (t_done) begin
                    t_load = 1'b1;
                    if (last) begin
                        state_d = S_WAIT_KEY;
                        idx_d   = '0;
                        t_val   = TW'(TIMEOUT_CYCLES - 1);
                    end else begin
                        state_d = S_PLAY_ON;
                        idx_d   = idx_q + 1'b1;
                        t_val   = TW'(NOTE_CYCLES - 1);
                    end
                end
            end
            S_WAIT_KEY: begin
                // A press on the final allowed cycle still wins over the timeout
                if (press) begin
                    cap_d   = key_in;
                    state_d = S_CHECK;
                end else if (t_done) begin
                    state_d = S_LOST;
                end
            end
            S_CHECK: begin
                state_d = (cap_q == exp_oh) ? S_WAIT_RELEASE : S_LOST;
            end
            S_WAIT_RELEASE: begin
                if (key_in == '0) begin
                    if (last) begin
                        state_d = (level_q == LW'(MAX_LEN)) ? S_WON : S_EXTEND;
                    end else begin
                        state_d = S_WAIT_KEY;
                        idx_d   = idx_q + 1'b1;
                        t_load  = 1'b1;
                        t_val   = TW'(TIMEOUT_CYCLES - 1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            idx_q       <= '0;
            lfsr_q      <= SEED;
            prev_keys_q <= '0;
            cap_q       <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            prev_keys_q <= prev_keys_d;
            cap_q       <= cap_d;
            mem_q       <= mem_d;
        end
    end

    always_comb begin
        case (state_q)
            S_PLAY_ON:  note_out = exp_oh;
            S_PLAY_GAP: note_out = '0;
            default:    note_out = key_in;
        endcase
    end

    assign state_out = state_q;
    assign level     = level_q;
    assign won       = (state_q == S_WON);
    assign lost      = (state_q == S_LOST);

endmodule

// File: tb/tb_sequence_game_core.sv
// Bench for sequence_game_core: table-driven opening, hand-written corner cases,
// and randomized games checked against a queue-based model of the note sequence.
module tb_sequence_game_core;

    localparam int MAX_LEN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] key_in = 4'b0;
    logic [3:0] note_out;
    logic [3:0] state_out;
    logic [1:0] level;
    logic       won, lost;

    int tests = 0;
    int fails = 0;
    int seq[$];
    logic [15:0] m_lfsr;

    sequence_game_core #(
        .NUM_KEYS(4), .MAX_LEN(MAX_LEN), .NOTE_CYCLES(2), .GAP_CYCLES(1),
        .TIMEOUT_CYCLES(20), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .note_out(note_out), .state_out(state_out), .level(level),
        .won(won), .lost(lost)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    // Free-running reference LFSR: one step per clock since reset release
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [3:0] onehot(input int n);
        logic [3:0] one;
        one = 4'b0001;
        return one << n;
    endfunction

    function automatic int cur_note();
        return int'(m_lfsr % 16'd4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic begin_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_extend", state_out, 1);
        chk("start_level0", level, 0);
        seq.delete();
        seq.push_back(cur_note());
    endtask

    task automatic playback();
        for (int i = 0; i < seq.size(); i++) begin
            tick();
            chk("play_on_1", state_out, 2);
            chk("play_note_1", note_out, onehot(seq[i]));
            if (i == 0) chk("round_level", level, seq.size());
            tick();
            chk("play_on_2", state_out, 2);
            chk("play_note_2", note_out, onehot(seq[i]));
            tick();
            chk("play_gap", state_out, 3);
            chk("gap_dark", note_out, 0);
        end
        tick();
        chk("wait_key_entry", state_out, 4);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("wait_key_hold", state_out, 4);
        end
    endtask

    task automatic press_expect(input logic [3:0] k, input bit good);
        key_in = k;
        tick();
        chk("check_state", state_out, 5);
        tick();
        if (good) begin
            chk("wait_release", state_out, 6);
        end else begin
            chk("lost_state", state_out, 8);
            chk("lost_flag", lost, 1);
            chk("won_flag_low", won, 0);
            key_in = 4'b0;
        end
    endtask

    function automatic logic [3:0] wrong_key(input logic [3:0] good);
        logic [3:0] k;
        k = good;
        while (k == good) k = 4'($urandom_range(1, 15));
        return k;
    endfunction

    // Plays a whole game; first_delay >= 0 fixes the idle cycles before the first press
    task automatic run_game(input bit allow_wrong, input int first_delay);
        logic [3:0] k;
        bit         good;
        int         n, d;
        begin_game();
        for (int r = 1; r <= MAX_LEN; r++) begin
            playback();
            n = seq.size();
            for (int i = 0; i < n; i++) begin
                d = (r == 1 && i == 0 && first_delay >= 0) ? first_delay : int'($urandom_range(0, 5));
                wait_cycles(d);
                k = onehot(seq[i]);
                if (allow_wrong && $urandom_range(0, 9) == 0) k = wrong_key(k);
                good = (k == onehot(seq[i]));
                press_expect(k, good);
                if (!good) return;
                for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                    tick();
                    chk("release_hold", state_out, 6);
                end
                key_in = 4'b0;
                tick();
                if (i < n - 1) begin
                    chk("next_key", state_out, 4);
                end else if (r == MAX_LEN) begin
                    chk("won_state", state_out, 7);
                    chk("won_flag", won, 1);
                    chk("won_lost_low", lost, 0);
                    chk("won_level", level, MAX_LEN);
                end else begin
                    chk("next_extend", state_out, 1);
                    seq.push_back(cur_note());
                end
            end
        end
    endtask

    typedef struct {
        logic       start;
        logic [3:0] key;
        int         st;
        int         lvl;
        int         nk;   // 0 mirrors key_in, 1 plays seq[0], 2 dark
    } vec_t;

    initial begin
        vec_t vecs[6];
        logic [3:0] exp_note;

        vecs[0] = '{1'b0, 4'b0101, 0, 0, 0};
        vecs[1] = '{1'b1, 4'b0000, 1, 0, 0};
        vecs[2] = '{1'b1, 4'b1111, 2, 1, 1};
        vecs[3] = '{1'b0, 4'b0000, 2, 1, 1};
        vecs[4] = '{1'b0, 4'b1000, 3, 1, 2};
        vecs[5] = '{1'b0, 4'b0000, 4, 1, 0};

        key_in = 4'b1010;
        #1;
        chk("rst_state", state_out, 0);
        chk("rst_level", level, 0);
        chk("rst_won", won, 0);
        chk("rst_lost", lost, 0);
        chk("rst_mirror", note_out, 4'b1010);
        tick();
        tick();
        reset  = 1'b0;
        key_in = 4'b0;

        // Opening from IDLE: start, one note lit for two clocks, one dark clock, wait
        for (int v = 0; v < 6; v++) begin
            start  = vecs[v].start;
            key_in = vecs[v].key;
            tick();
            if (vecs[v].st == 1) begin
                seq.delete();
                seq.push_back(cur_note());
            end
            exp_note = (vecs[v].nk == 1) ? onehot(seq[0]) :
                       (vecs[v].nk == 2) ? 4'b0 : key_in;
            chk("vec_state", state_out, vecs[v].st);
            chk("vec_level", level, vecs[v].lvl);
            chk("vec_note", note_out, exp_note);
        end
        start = 1'b0;

        // Timeout: already in the first WAIT_KEY cycle; 19 more, then LOST
        wait_cycles(19);
        tick();
        chk("timeout_lost", state_out, 8);
        chk("timeout_flag", lost, 1);

        // Wrong single key in round 1
        begin_game();
        playback();
        press_expect(onehot((seq[0] + 1) % 4), 1'b0);

        // Two keys at once always fails
        begin_game();
        playback();
        press_expect(4'b0011, 1'b0);

        // Press in the 19th WAIT_KEY cycle, then complete a full win
        run_game(1'b0, 18);

        // Asynchronous reset in the middle of round 2 playback
        begin_game();
        playback();
        press_expect(onehot(seq[0]), 1'b1);
        key_in = 4'b0;
        tick();
        chk("r2_extend", state_out, 1);
        tick();
        chk("r2_play_on", state_out, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_state", state_out, 0);
        chk("async_level", level, 0);
        chk("async_won", won, 0);
        chk("async_lost", lost, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_game(1'b0, -1);

        for (int g = 0; g < 10; g++) begin
            for (int w = 0; w < int'($urandom_range(0, 7)); w++) tick();
            run_game(1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
